// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short/long/double event pulses.
// Optional double-click detection is compiled in with `define DOUBLE_CLICK_EN.
module button_event_decoder #(
  parameter int unsigned FREQ      = 125,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_busy
);

  localparam int unsigned TickCycles = FREQ * 1000;
  localparam int unsigned PreW       = $clog2(TickCycles);
  localparam int unsigned MaxMs      = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
  localparam int unsigned MsW        = $clog2(MaxMs + 1);

  localparam logic [PreW-1:0] PreLast = PreW'(TickCycles - 1);
  localparam logic [MsW-1:0]  LongPre = MsW'(LONG_MS - 1);
`ifdef DOUBLE_CLICK_EN
  localparam logic [MsW-1:0]  DclickPre = MsW'(DCLICK_MS - 1);
`endif

  if (FREQ < 1) begin : g_chk_freq
    $error("FREQ must be >= 1");
  end
  if (LONG_MS < 1) begin : g_chk_long
    $error("LONG_MS must be >= 1");
  end
  if (DCLICK_MS < 1) begin : g_chk_dclick
    $error("DCLICK_MS must be >= 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StPressed,
`ifdef DOUBLE_CLICK_EN
    StWait2nd,
    StPressed2,
`endif
    StLongHeld
  } state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [MsW-1:0]  ms_q, ms_d;
  logic            i_sig_q;
  logic            held_q, held_d;
  logic            press_q, release_q, short_q, long_q;
  logic            release_d, short_d, long_d;
  logic            rise, fall, tick, long_hit;
`ifdef DOUBLE_CLICK_EN
  logic            double_q, double_d;
  logic            dclick_hit;
`endif

  always_comb begin
    rise     = i_sig & ~i_sig_q;
    fall     = ~i_sig & i_sig_q;
    tick     = (pre_q == PreLast);
    // Compare against the pre-increment count so the event lands on the edge the count is reached.
    long_hit = tick && (ms_q == LongPre);
`ifdef DOUBLE_CLICK_EN
    dclick_hit = tick && (ms_q == DclickPre);
    double_d   = 1'b0;
`endif
    state_d   = state_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    release_d = fall & ~held_q;
    held_d    = held_q & i_sig;

    case (state_q)
      StIdle: begin
        if (rise) state_d = StPressed;
      end
      StPressed: begin
        // A fall on the same edge as the long threshold wins and counts as a short press.
        if (fall) begin
`ifdef DOUBLE_CLICK_EN
          state_d = StWait2nd;
`else
          short_d = 1'b1;
          state_d = StIdle;
`endif
        end else if (long_hit) begin
          long_d  = 1'b1;
          state_d = StLongHeld;
        end
      end
      StLongHeld: begin
        if (fall) state_d = StIdle;
      end
`ifdef DOUBLE_CLICK_EN
      StWait2nd: begin
        if (rise) begin
          double_d = 1'b1;
          state_d  = StPressed2;
        end else if (dclick_hit) begin
          short_d = 1'b1;
          state_d = StIdle;
        end
      end
      StPressed2: begin
        if (fall) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Every state change restarts the time base so each interval is measured from its own edge.
    if (state_d != state_q) begin
      pre_d = '0;
      ms_d  = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      ms_d  = ms_q;
      if (tick && (ms_q != '1)) ms_d = ms_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      ms_q      <= '0;
      i_sig_q   <= i_sig;
      held_q    <= i_sig;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      double_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      i_sig_q   <= i_sig;
      held_q    <= held_d;
      press_q   <= rise;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
`ifdef DOUBLE_CLICK_EN
      double_q  <= double_d;
`endif
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_short   = short_q;
  assign o_long    = long_q;
  assign o_busy    = (state_q != StIdle);
`ifdef DOUBLE_CLICK_EN
  assign o_double  = double_q;
`else
  assign o_double  = 1'b0;
`endif

endmodule
